lfsr_seq_checker: RTL and testbench



---
 rtl/lfsr_pkg.sv | 20 ++
 rtl/lfsr_next.sv | 16 +
 rtl/lfsr_seq_checker.sv | 152 +++++++++++++++
 tb/tb_lfsr_seq_checker.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared LFSR constants, checker state encoding and feedback function
package lfsr_pkg;

    localparam int              DEF_WIDTH = 4;
    localparam logic [3:0]      DEF_TAPS  = 4'b1100;
    localparam int              MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } chk_state_e;

    // Callers zero-extend narrower states and masks to MAX_WIDTH.
    function automatic logic lfsr_fb(input logic [MAX_WIDTH-1:0] s,
                                     input logic [MAX_WIDTH-1:0] taps);
        return ^(s & taps);
    endfunction

endpackage

// File: rtl/lfsr_next.sv
// rtl/lfsr_next.sv - one LFSR step: feedback bit and shifted next state
module lfsr_next
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = DEF_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = DEF_TAPS
) (
    input  logic [WIDTH-1:0] state_i,
    output logic             fb_o,
    output logic [WIDTH-1:0] next_o
);

    assign fb_o   = lfsr_fb(MAX_WIDTH'(state_i), MAX_WIDTH'(TAPS));
    assign next_o = {state_i[WIDTH-2:0], fb_o};

endmodule

// File: rtl/lfsr_seq_checker.sv
// rtl/lfsr_seq_checker.sv - self-synchronising LFSR sequence checker with flywheel and error count
module lfsr_seq_checker
    import lfsr_pkg::*;
#(
    parameter int               WIDTH      = DEF_WIDTH,
    parameter logic [WIDTH-1:0] TAPS       = DEF_TAPS,
    parameter int               LOCK_COUNT = 8,
    parameter int               ERR_THRESH = 3,
    parameter int               CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid,
    input  logic             din,
    input  logic             clear_count,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_count
);

    localparam int LW = $clog2(WIDTH + 1);
    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int EW = $clog2(ERR_THRESH + 1);

    localparam logic [LW-1:0]    LOAD_ONE   = LW'(1);
    localparam logic [LW-1:0]    LOAD_LAST  = LW'(WIDTH - 1);
    localparam logic [MW-1:0]    MATCH_ONE  = MW'(1);
    localparam logic [MW-1:0]    MATCH_LAST = MW'(LOCK_COUNT - 1);
    localparam logic [EW-1:0]    MISS_ONE   = EW'(1);
    localparam logic [EW-1:0]    MISS_LAST  = EW'(ERR_THRESH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    chk_state_e       state_q,     state_d;
    logic [WIDTH-1:0] shadow_q,    shadow_d;
    logic [LW-1:0]    load_cnt_q,  load_cnt_d;
    logic [MW-1:0]    match_cnt_q, match_cnt_d;
    logic [EW-1:0]    miss_cnt_q,  miss_cnt_d;
    logic             locked_q,    locked_d;
    logic             err_q,       err_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    logic             pred;
    logic [WIDTH-1:0] shadow_flywheel;
    logic [WIDTH-1:0] shadow_din;

    lfsr_next #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_next (
        .state_i (shadow_q),
        .fb_o    (pred),
        .next_o  (shadow_flywheel)
    );

    assign shadow_din = {shadow_q[WIDTH-2:0], din};

    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        load_cnt_d  = load_cnt_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        locked_d    = locked_q;
        err_d       = 1'b0;
        err_count_d = clear_count ? '0 : err_count_q;

        if (din_valid) begin
            unique case (state_q)
                ST_LOAD: begin
                    shadow_d   = shadow_din;
                    load_cnt_d = load_cnt_q + LOAD_ONE;
                    if (load_cnt_q == LOAD_LAST) begin
                        state_d     = ST_VERIFY;
                        match_cnt_d = '0;
                    end
                end
                ST_VERIFY: begin
                    shadow_d = shadow_din;
                    if (din != pred) begin
                        // The offending bit becomes the first bit of the new load.
                        state_d    = ST_LOAD;
                        load_cnt_d = LOAD_ONE;
                    end else if (shadow_q == '0) begin
                        match_cnt_d = '0;
                    end else if (match_cnt_q == MATCH_LAST) begin
                        state_d     = ST_LOCKED;
                        locked_d    = 1'b1;
                        match_cnt_d = '0;
                        miss_cnt_d  = '0;
                    end else begin
                        match_cnt_d = match_cnt_q + MATCH_ONE;
                    end
                end
                ST_LOCKED: begin
                    // Flywheel on the prediction so a single line error is flagged once.
                    shadow_d = shadow_flywheel;
                    if (din != pred) begin
                        err_d = 1'b1;
                        if (err_count_d != CNT_MAX) begin
                            err_count_d = err_count_d + CNT_ONE;
                        end
                        if (miss_cnt_q == MISS_LAST) begin
                            state_d    = ST_LOAD;
                            locked_d   = 1'b0;
                            load_cnt_d = '0;
                            shadow_d   = '0;
                            miss_cnt_d = '0;
                        end else begin
                            miss_cnt_d = miss_cnt_q + MISS_ONE;
                        end
                    end else begin
                        miss_cnt_d = '0;
                    end
                end
                default: begin
                    state_d    = ST_LOAD;
                    locked_d   = 1'b0;
                    load_cnt_d = '0;
                    shadow_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_LOAD;
            shadow_q    <= '0;
            load_cnt_q  <= '0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            load_cnt_q  <= load_cnt_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

    assign locked    = locked_q;
    assign err       = err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// tb/tb_lfsr_seq_checker.sv - randomized self-checking bench for lfsr_seq_checker
module tb_lfsr_seq_checker;

    localparam int W    = 4;
    localparam int LOCK = 8;
    localparam int THR  = 3;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          din_valid = 1'b0;
    logic          din = 1'b0;
    logic          clear_count = 1'b0;
    logic          locked;
    logic          err;
    logic [CW-1:0] err_count;

    logic [W-1:0]  taps_v = 4'b1100;
    logic [W-1:0]  g;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    // Reference model: history as a bit queue (newest at the back), modes as small ints.
    int m_mode, m_load, m_match, m_miss, m_cnt;
    bit m_locked, m_err;
    bit m_hist[$];

    lfsr_seq_checker #(
        .WIDTH      (W),
        .TAPS       (4'b1100),
        .LOCK_COUNT (LOCK),
        .ERR_THRESH (THR),
        .CNT_W      (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .din_valid   (din_valid),
        .din         (din),
        .clear_count (clear_count),
        .locked      (locked),
        .err         (err),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_load = 0; m_match = 0; m_miss = 0; m_cnt = 0;
        m_locked = 1'b0; m_err = 1'b0;
        m_hist = {};
        for (int i = 0; i < W; i++) m_hist.push_back(1'b0);
    endtask

    function automatic bit m_pred();
        bit p = 1'b0;
        for (int k = 0; k < W; k++) if (taps_v[k]) p ^= m_hist[W-1-k];
        return p;
    endfunction

    function automatic bit m_nonzero();
        bit nz = 1'b0;
        foreach (m_hist[i]) nz |= m_hist[i];
        return nz;
    endfunction

    task automatic m_push(input bit b);
        m_hist.push_back(b);
        void'(m_hist.pop_front());
    endtask

    task automatic model_step(input bit v, input bit d, input bit c);
        bit p, nz;
        m_err = 1'b0;
        if (c) m_cnt = 0;
        if (v) begin
            p  = m_pred();
            nz = m_nonzero();
            if (m_mode == 0) begin
                m_push(d);
                m_load++;
                if (m_load == W) begin m_mode = 1; m_match = 0; end
            end else if (m_mode == 1) begin
                m_push(d);
                if (d != p) begin
                    m_mode = 0; m_load = 1;
                end else if (!nz) begin
                    m_match = 0;
                end else begin
                    m_match++;
                    if (m_match == LOCK) begin
                        m_mode = 2; m_locked = 1'b1; m_match = 0; m_miss = 0;
                    end
                end
            end else begin
                m_push(p);
                if (d != p) begin
                    m_err = 1'b1;
                    m_cnt = (m_cnt >= CMAX) ? CMAX : m_cnt + 1;
                    m_miss++;
                    if (m_miss == THR) begin
                        m_locked = 1'b0; m_mode = 0; m_load = 0; m_miss = 0;
                        foreach (m_hist[i]) m_hist[i] = 1'b0;
                    end
                end else begin
                    m_miss = 0;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("locked", 32'(locked), 32'(m_locked));
            check("err", 32'(err), 32'(m_err));
            check("err_count", 32'(err_count), 32'(m_cnt));
        end
    end

    task automatic gen_bit(output logic b);
        b = ^(g & taps_v);
        g = {g[W-2:0], b};
    endtask

    task automatic drive(input bit v, input bit d, input bit c);
        @(negedge clk);
        din_valid = v; din = d; clear_count = c;
        @(posedge clk);
        if (rst) model_step(v, d, c);
    endtask

    task automatic send(input bit v, input bit inj, input bit c);
        logic b;
        if (v) begin
            gen_bit(b);
            b = b ^ inj;
        end else begin
            b = 1'($urandom);
        end
        drive(v, b, c);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) drive(1'($urandom), 1'($urandom), 1'($urandom));
        #1;
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        @(negedge clk);
        rst = 1'b1; din_valid = 1'b0; clear_count = 1'b0;
        for (int i = 0; i < 3; i++) drive(1'b0, 1'($urandom), 1'b0);
    endtask

    initial begin
        int exp_seq[15] = '{0,0,1,1,0,1,0,1,1,1,1,0,0,0,1};
        int nv;
        logic b;
        bit burst;
        int burst_left;

        model_reset();
        cmp_en = 1'b1;

        // Generator convention against the hand-listed sequence from seed 0001.
        g = 4'b0001;
        for (int i = 0; i < 15; i++) begin
            gen_bit(b);
            check("gen_seq", 32'(b), 32'(exp_seq[i]));
        end

        // Continuous clean stream: lock exactly on bit 12.
        do_reset();
        g = 4'b0001;
        for (int i = 1; i <= 15; i++) begin
            send(1'b1, 1'b0, 1'b0);
            #1;
            if (i == 11) check("lock_bit11", 32'(locked), 32'd0);
            if (i == 12) begin
                check("lock_bit12", 32'(locked), 32'd1);
                check("model_lock12", 32'(m_locked), 32'd1);
            end
        end

        // Gapped stream: lock on the 12th valid bit, state held through gaps.
        do_reset();
        g = 4'b0001;
        nv = 0;
        while (nv < 12) begin
            send(1'b1, 1'b0, 1'b0);
            nv++;
            #1;
            if (nv == 11) check("gap_lock_bit11", 32'(locked), 32'd0);
            if (nv == 12) check("gap_lock_bit12", 32'(locked), 32'd1);
            send(1'b0, 1'b0, 1'b0);
            #1;
            if (nv == 11) check("gap_hold", 32'(locked), 32'd0);
        end

        // Single inverted bit while locked.
        send(1'b1, 1'b1, 1'b0);
        #1;
        check("single_err", 32'(err), 32'd1);
        check("single_cnt", 32'(err_count), 32'd1);
        check("single_locked", 32'(locked), 32'd1);
        send(1'b1, 1'b0, 1'b0);
        #1;
        check("single_err_pulse", 32'(err), 32'd0);
        for (int i = 0; i < 20; i++) send(1'b1, 1'b0, 1'b0);
        #1;
        check("single_no_more", 32'(err_count), 32'd1);

        // Three consecutive errors drop lock, clean stream relocks after 12.
        send(1'b1, 1'b0, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            send(1'b1, 1'b1, 1'b0);
            #1;
            check("burst_locked", 32'(locked), (i == 3) ? 32'd0 : 32'd1);
        end
        check("burst_cnt", 32'(err_count), 32'd3);
        for (int i = 1; i <= 12; i++) begin
            send(1'b1, 1'b0, 1'b0);
            #1;
            if (i == 11) check("relock_bit11", 32'(locked), 32'd0);
            if (i == 12) check("relock_bit12", 32'(locked), 32'd1);
        end

        // All-zero input never locks; real stream locks 12 bits after first nonzero history.
        do_reset();
        for (int i = 0; i < 30; i++) drive(1'b1, 1'b0, 1'b0);
        #1;
        check("zeros_locked", 32'(locked), 32'd0);
        g = 4'b0001;
        for (int i = 1; i <= 14; i++) begin
            send(1'b1, 1'b0, 1'b0);
            #1;
            if (i == 13) check("zero_relock13", 32'(locked), 32'd0);
            if (i == 14) check("zero_relock14", 32'(locked), 32'd1);
        end

        // Clear on the same edge as a mismatch.
        send(1'b1, 1'b1, 1'b0);
        send(1'b1, 1'b0, 1'b0);
        send(1'b1, 1'b1, 1'b0);
        send(1'b1, 1'b0, 1'b0);
        #1;
        check("pre_clear_cnt", 32'(err_count), 32'd2);
        send(1'b1, 1'b1, 1'b1);
        #1;
        check("clear_with_err", 32'(err_count), 32'd1);

        // Saturation: 300 isolated errors.
        for (int i = 0; i < 300; i++) begin
            send(1'b1, 1'b1, 1'b0);
            send(1'b1, 1'b0, 1'b0);
        end
        #1;
        check("sat_cnt", 32'(err_count), 32'd255);
        check("sat_locked", 32'(locked), 32'd1);

        // Asynchronous reset while locked.
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check("async_locked", 32'(locked), 32'd0);
        check("async_cnt", 32'(err_count), 32'd0);

        // Randomized traffic with sparse errors, bursts and clears.
        do_reset();
        g = 4'(($urandom % 15) + 1);
        burst_left = 0;
        for (int i = 0; i < 1500; i++) begin
            if (burst_left == 0 && ($urandom % 200) == 0) burst_left = 3;
            burst = (burst_left > 0);
            if (burst) burst_left--;
            send(($urandom % 10) < 7, burst || (($urandom % 100) < 3), ($urandom % 100) < 2);
        end

        @(negedge clk);
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
